// File: rtl/regbank_wb_queue.sv
// regbank_wb_queue
//   Write-back queue in front of the 32x32 register bank. Two producer ports
//   (A, B) push register writes into an in-order FIFO; one entry per cycle is
//   drained into a registered bank write port. Pending (uncommitted) data is
//   forwarded combinationally for the bank's two read selects.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   a_valid/a_dr/a_data   port A request, a_ready = accepted when valid
//   b_valid/b_dr/b_data   port B request, b_ready = accepted when valid
//   write/dr/wrData       registered bank write port
//   sr1, sr2              bank read selects (forwarding lookup keys)
//   fwd1_hit/fwd1_data    youngest pending write to sr1 (data 0 on miss)
//   fwd2_hit/fwd2_data    youngest pending write to sr2 (data 0 on miss)
//   pending               FIFO occupancy, output register not included
module regbank_wb_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       a_valid,
   input  logic [AW-1:0]              a_dr,
   input  logic [DW-1:0]              a_data,
   output logic                       a_ready,
   input  logic                       b_valid,
   input  logic [AW-1:0]              b_dr,
   input  logic [DW-1:0]              b_data,
   output logic                       b_ready,
   output logic                       write,
   output logic [AW-1:0]              dr,
   output logic [DW-1:0]              wrData,
   input  logic [AW-1:0]              sr1,
   input  logic [AW-1:0]              sr2,
   output logic                       fwd1_hit,
   output logic [DW-1:0]              fwd1_data,
   output logic                       fwd2_hit,
   output logic [DW-1:0]              fwd2_data,
   output logic [$clog2(DEPTH):0]     pending
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [AW-1:0]    mem_dr_q   [DEPTH];
   logic [AW-1:0]    mem_dr_d   [DEPTH];
   logic [DW-1:0]    mem_data_q [DEPTH];
   logic [DW-1:0]    mem_data_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q, write_d;
   logic [AW-1:0]    dr_q, dr_d;
   logic [DW-1:0]    wr_data_q, wr_data_d;

   logic [CNT_W-1:0] free;
   logic             push_a, push_b, pop;
   logic [PTR_W-1:0] b_idx;
   logic [PTR_W-1:0] idx;

   // Free space is taken from current occupancy only; a pop at the same edge
   // does not make room for a push.
   assign free    = CNT_W'(DEPTH) - cnt_q;
   assign a_ready = (free != '0);
   assign b_ready = (free >= CNT_W'(2)) || ((free != '0) && !a_valid);
   assign push_a  = a_valid && a_ready;
   assign push_b  = b_valid && b_ready;
   assign pop     = (cnt_q != '0);

   assign write   = write_q;
   assign dr      = dr_q;
   assign wrData  = wr_data_q;
   assign pending = cnt_q;

   always_comb begin
      mem_dr_d   = mem_dr_q;
      mem_data_d = mem_data_q;
      // B lands behind A when both are accepted in the same cycle.
      b_idx      = push_a ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      if (push_a) begin
         mem_dr_d[wr_ptr_q]   = a_dr;
         mem_data_d[wr_ptr_q] = a_data;
      end
      if (push_b) begin
         mem_dr_d[b_idx]   = b_dr;
         mem_data_d[b_idx] = b_data;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
      write_d  = pop;
      dr_d      = pop ? mem_dr_q[rd_ptr_q]   : dr_q;
      wr_data_d = pop ? mem_data_q[rd_ptr_q] : wr_data_q;
   end

   // Forwarding: start from the output register (oldest candidate), then walk
   // the FIFO head to tail so later (younger) matches override earlier ones.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      idx       = '0;
      if (write_q && (dr_q == sr1)) begin
         fwd1_hit  = 1'b1;
         fwd1_data = wr_data_q;
      end
      if (write_q && (dr_q == sr2)) begin
         fwd2_hit  = 1'b1;
         fwd2_data = wr_data_q;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if (i < 32'(cnt_q)) begin
            if (mem_dr_q[idx] == sr1) begin
               fwd1_hit  = 1'b1;
               fwd1_data = mem_data_q[idx];
            end
            if (mem_dr_q[idx] == sr2) begin
               fwd2_hit  = 1'b1;
               fwd2_data = mem_data_q[idx];
            end
         end
      end
   end

   // Storage array needs no reset: occupancy gates every read of it.
   always_ff @(posedge clk) begin
      mem_dr_q   <= mem_dr_d;
      mem_data_q <= mem_data_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         write_q   <= 1'b0;
         dr_q      <= '0;
         wr_data_q <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         write_q   <= write_d;
         dr_q      <= dr_d;
         wr_data_q <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_regbank_wb_queue.sv
// Testbench for regbank_wb_queue: directed scenarios plus a randomized phase,
// all checked against a queue-based reference model and a simple bank array.
module tb_regbank_wb_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          clk;
   logic          reset;
   logic          a_valid, b_valid;
   logic [AW-1:0] a_dr, b_dr;
   logic [DW-1:0] a_data, b_data;
   logic          a_ready, b_ready;
   logic          write;
   logic [AW-1:0] dr;
   logic [DW-1:0] wrData;
   logic [AW-1:0] sr1, sr2;
   logic          fwd1_hit, fwd2_hit;
   logic [DW-1:0] fwd1_data, fwd2_data;
   logic [$clog2(DEPTH):0] pending;

   regbank_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_dr(a_dr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_dr(b_dr), .b_data(b_data), .b_ready(b_ready),
      .write(write), .dr(dr), .wrData(wrData),
      .sr1(sr1), .sr2(sr2),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
      .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
      .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] dr;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   logic          m_write;
   logic [AW-1:0] m_dr;
   logic [DW-1:0] m_data;
   logic [DW-1:0] bank_mem [32];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Youngest pending write to a register: queue tail first, then output reg.
   task automatic ref_fwd(input logic [AW-1:0] sr, output logic hit, output logic [DW-1:0] data);
      hit  = 1'b0;
      data = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (!hit && mq[i].dr == sr) begin
            hit  = 1'b1;
            data = mq[i].data;
         end
      end
      if (!hit && m_write && m_dr == sr) begin
         hit  = 1'b1;
         data = m_data;
      end
   endtask

   // One clock cycle: check everything mid-cycle, then advance the model.
   task automatic step();
      int            free;
      logic          exp_ar, exp_br, acc_a, acc_b, h;
      logic [DW-1:0] d;
      ent_t          e;
      @(negedge clk);
      free   = DEPTH - mq.size();
      exp_ar = (free >= 1);
      exp_br = (free >= 2) || (free >= 1 && !a_valid);
      chk("a_ready", 32'(a_ready), 32'(exp_ar));
      chk("b_ready", 32'(b_ready), 32'(exp_br));
      chk("pending", 32'(pending), 32'(mq.size()));
      chk("write",   32'(write),   32'(m_write));
      chk("dr",      32'(dr),      32'(m_dr));
      chk("wrData",  wrData,       m_data);
      ref_fwd(sr1, h, d);
      chk("fwd1_hit",  32'(fwd1_hit), 32'(h));
      chk("fwd1_data", fwd1_data,     d);
      ref_fwd(sr2, h, d);
      chk("fwd2_hit",  32'(fwd2_hit), 32'(h));
      chk("fwd2_data", fwd2_data,     d);
      // The bank commits whatever is on its write port at the coming edge.
      if (write === 1'b1) bank_mem[dr] = wrData;
      acc_a = a_valid && exp_ar && !reset;
      acc_b = b_valid && exp_br && !reset;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_write = 1'b0;
         m_dr    = '0;
         m_data  = '0;
      end else begin
         if (mq.size() > 0) begin
            e       = mq.pop_front();
            m_write = 1'b1;
            m_dr    = e.dr;
            m_data  = e.data;
         end else begin
            m_write = 1'b0;
         end
         if (acc_a) mq.push_back('{dr: a_dr, data: a_data});
         if (acc_b) mq.push_back('{dr: b_dr, data: b_data});
      end
      #1;
   endtask

   task automatic idle();
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      a_valid = 1'b0; a_dr = '0; a_data = '0;
      b_valid = 1'b0; b_dr = '0; b_data = '0;
      sr1 = '0; sr2 = '0;
      m_write = 1'b0; m_dr = '0; m_data = '0;
      for (int i = 0; i < 32; i++) bank_mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      // Reset held: state zero, valid requests ignored.
      a_valid = 1'b1; a_dr = 5'd9; a_data = 32'hdead;
      step();
      reset = 1'b0;
      idle();
      step();

      // Single write through A.
      sr1 = 5'd3; sr2 = 5'd4;
      a_valid = 1'b1; a_dr = 5'd3; a_data = 32'd30;
      step();
      idle();
      repeat (3) step();

      // Dual push in one cycle.
      a_valid = 1'b1; a_dr = 5'd1; a_data = 32'd10;
      b_valid = 1'b1; b_dr = 5'd2; b_data = 32'd20;
      sr1 = 5'd1; sr2 = 5'd2;
      step();
      idle();
      repeat (4) step();

      // Fill and backpressure: both ports valid for 4 cycles.
      for (int k = 0; k < 4; k++) begin
         a_valid = 1'b1; a_dr = 5'(2 * k + 1); a_data = 32'(10 * (2 * k + 1));
         b_valid = 1'b1; b_dr = 5'(2 * k + 2); b_data = 32'(10 * (2 * k + 2));
         step();
      end
      // Single free slot with A idle: B takes it.
      a_valid = 1'b0;
      step();
      idle();
      repeat (6) step();

      // Forwarding priority: two writes to r5, youngest wins.
      sr1 = 5'd5; sr2 = 5'd6;
      a_valid = 1'b1; a_dr = 5'd5; a_data = 32'd50;
      step();
      a_data = 32'd55;
      step();
      idle();
      repeat (4) step();

      // Mid-stream reset with entries pending.
      a_valid = 1'b1; a_dr = 5'd7;  a_data = 32'h111;
      b_valid = 1'b1; b_dr = 5'd8;  b_data = 32'h222;
      step();
      a_dr = 5'd10; a_data = 32'h333;
      b_dr = 5'd11; b_data = 32'h444;
      step();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (3) step();

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         a_valid = 1'($urandom_range(0, 1));
         b_valid = 1'($urandom_range(0, 1));
         a_dr    = 5'($urandom_range(0, 7));
         b_dr    = 5'($urandom_range(0, 7));
         a_data  = $urandom;
         b_data  = $urandom;
         sr1     = 5'($urandom_range(0, 7));
         sr2     = 5'($urandom_range(0, 7));
         reset   = ($urandom_range(0, 49) == 0);
         step();
      end
      reset = 1'b0;
      idle();
      repeat (6) step();

      // End-to-end: reg[k] = 10k via alternating ports, then read back.
      for (int k = 0; k < 32; k++) begin
         sr1 = 5'(k); sr2 = 5'((k + 1) % 32);
         if (k % 2 == 0) begin
            a_valid = 1'b1; a_dr = 5'(k); a_data = 32'(10 * k);
            b_valid = 1'b0;
         end else begin
            b_valid = 1'b1; b_dr = 5'(k); b_data = 32'(10 * k);
            a_valid = 1'b0;
         end
         step();
      end
      idle();
      repeat (4) step();
      for (int k = 0; k < 31; k++) begin
         sr1 = 5'(k); sr2 = 5'(k + 1);
         #1;
         chk("bank_rd1", bank_mem[sr1], 32'(10 * k));
         chk("bank_rd2", bank_mem[sr2], 32'(10 * (k + 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regbank_wb_queue.md
# regbank_wb_queue

Write-back queue that sits directly upstream of the 32x32 register bank. It accepts register write requests from two producer ports (A and B), buffers them in order in a small FIFO, and drains them one per cycle onto the bank's single write port (write/dr/wrData). It also forwards not-yet-committed data to the bank's two read selects, so consumers can see the youngest pending value for sr1/sr2.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  port A write request
- a_dr  in  AW  port A destination register
- a_data  in  DW  port A write data
- a_ready  out  1  port A accepted this cycle when a_valid && a_ready
- b_valid  in  1  port B write request
- b_dr  in  AW  port B destination register
- b_data  in  DW  port B write data
- b_ready  out  1  port B accepted this cycle when b_valid && b_ready
- write  out  1  to bank write enable; registered
- dr  out  AW  to bank destination select; registered
- wrData  out  DW  to bank write data; registered
- sr1, sr2  in  AW  read selects, same values the bank receives
- fwd1_hit, fwd2_hit  out  1  a pending write to sr1/sr2 exists
- fwd1_data, fwd2_data  out  DW  youngest pending data for sr1/sr2; 0 when not hit
- pending  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register

## Operation
- free = DEPTH − pending, taken from current state. The same-edge pop is not credited.
- a_ready = (free ≥ 1).
- b_ready = (free ≥ 2) || (free ≥ 1 && !a_valid). This is a combinational path from a_valid to b_ready.
- Both ports accepted in one cycle: A is pushed first (older), then B. At most 2 pushes per edge.
- Pop: at each edge where pending > 0 (pre-edge value), the head entry loads into the output register with write=1, dr=entry.dr, wrData=entry.data.
- At an edge where pending == 0, write goes to 0. dr and wrData hold their previous values.
- An entry pushed at edge N is not poppable before edge N+1. There is no FIFO bypass.
- Occupancy update per edge: pending_next = pending + pushes − pop. It never exceeds DEPTH, which the ready rules guarantee.
- Read and write pointers wrap modulo DEPTH.
- Forwarding is combinational. Search set, youngest first:
  - FIFO entries, tail to head;
  - then the output register, only when write=1.
- For each search, the first entry whose dr == srX sets fwdX_hit=1 and fwdX_data to that entry's data. Same-cycle inputs on ports A/B are not searched.
- Register 0 gets no special handling; writes to dr=0 are queued and forwarded like any other.
- Port order and FIFO order are preserved to the bank. Duplicate destinations are not merged.

## Timing
- Reset, sampled at an edge:
  - pending=0, pointers=0, write=0, dr=0, wrData=0.
  - Inputs in that cycle are not accepted, and queued entries are discarded.
  - Reset mid-operation drops all pending writes. write is 0 the cycle after.
- Outputs during and immediately after reset: a_ready=1, b_ready=1, fwd*_hit=0, fwd*_data=0.
- Latency into an empty queue: request accepted at edge N, write=1 during cycle N+1, bank commits at edge N+2.
- Throughput: one bank write per cycle, sustained while pending > 0.
- Full (pending == DEPTH): a_ready=0 and b_ready=0, even in a cycle where a pop occurs.
- Single free slot: only one request is accepted.
  - a_valid=1: A takes the slot and B waits.
  - a_valid=0: B takes the slot.
- Simultaneous push and pop at an edge: both take effect, and pending changes by pushes − 1.

## Test plan
- Single write: reset, then A pushes dr=3, data=30 at edge 1 -> write=1, dr=3, wrData=30 during cycle 2 only; pending returns to 0.
- Dual push: A {dr=1, data=10} and B {dr=2, data=20} in the same cycle -> bank sees dr=1 then dr=2 on consecutive cycles; pending peaks at 2.
- Fill and backpressure: DEPTH=4, both ports valid every cycle for 4 cycles, data 10·k -> a_ready/b_ready drop exactly as the free rules give; bank receives 10·k in A-before-B order with no loss or duplication.
- Forwarding priority: queue dr=5 with data 50, then dr=5 with data 55, and set sr1=5, sr2=6 -> fwd1_hit=1, fwd1_data=55; after the 55 entry enters the output register, fwd1_data is still 55; after both are drained, fwd1_hit=0; fwd2_hit stays 0 throughout.
- Mid-stream reset: 3 entries pending, assert reset for 1 cycle -> write=0, pending=0, fwd*_hit=0 next cycle; discarded data never reaches the bank.
- End-to-end with bank: write reg[k] = 10·k for k=0..31 through alternating ports, then read pairs (sr1=k, sr2=k+1) -> bank returns 10·k and 10·(k+1).
